// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Purpose:
//   Consumer side of the hazard-detection stall interface. Converts the
//   ID-stage stall request, branch/jump redirect, memory-ready handshakes and
//   the HLT decode into per-cycle write/flush/bubble enables for the PC,
//   IF/ID, ID/EX and later pipeline registers. Also keeps saturating
//   stall/flush event counters and a sticky stall-timeout watchdog.
//
// Parameters:
//   CNT_W        width of stall_count / flush_count
//   STALL_LIMIT  consecutive stall cycles tolerated before stall_timeout sets
//   DRAIN_CYCLES cycles spent retiring the back end after HLT before halting
//
// Ports:
//   clk            in   pipeline clock, rising edge
//   reset          in   asynchronous, active-high reset
//   stall          in   hazard-unit stall request (ID stage)
//   flush_req      in   taken branch / jump resolved in ID
//   i_ready        in   instruction memory returned a fetch this cycle
//   d_req          in   MEM stage has a data access outstanding
//   d_ready        in   data memory completed its access this cycle
//   halt_in        in   HLT decoded in ID
//   pc_write       out  PC register load enable
//   pc_sel         out  1 = load redirect target, 0 = PC+1
//   if_id_write    out  IF/ID register load enable
//   if_id_flush    out  load NOP into IF/ID (meaningful only with if_id_write)
//   id_ex_bubble   out  load all-zero control word into ID/EX
//   pipe_hold      out  freeze ID/EX, EX/MEM, MEM/WB during a memory wait
//   halted         out  processor halted
//   stall_timeout  out  sticky: stall held longer than STALL_LIMIT cycles
//   stall_count    out  saturating count of stall cycles
//   flush_count    out  saturating count of accepted flushes
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int CNT_W        = 16,
    parameter int STALL_LIMIT  = 8,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush_req,
    input  logic             i_ready,
    input  logic             d_req,
    input  logic             d_ready,
    input  logic             halt_in,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic             halted,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int CONSEC_W = $clog2(STALL_LIMIT + 1);
    localparam int DRAIN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEMWAIT,
        ST_DRAIN,
        ST_HALT
    } state_t;

    state_t               state_q, state_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [CONSEC_W-1:0]  consec_q, consec_d;
    logic                 timeout_q, timeout_d;

    logic                 run_rules;
    logic                 stall_hit;
    logic                 flush_hit;

    // State register and all counters. Reset returns every flop to its idle
    // value immediately, so an interrupted memory wait or drain leaves nothing
    // behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            consec_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            consec_q    <= consec_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next state and enables. Outputs respond in the same cycle as the
    // inputs. The memory wait outranks everything so no instruction is lost
    // while data memory is busy. A MEMWAIT cycle in which d_ready arrives is
    // handled exactly like a RUN cycle, including a possible move to DRAIN.
    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;
        halted       = 1'b0;
        run_rules    = 1'b0;
        stall_hit    = 1'b0;
        flush_hit    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (d_req && !d_ready) begin
                    pipe_hold = 1'b1;
                    state_d   = ST_MEMWAIT;
                end else begin
                    run_rules = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                if (!d_ready) begin
                    pipe_hold = 1'b1;
                end else begin
                    run_rules = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // A pending data access pauses the drain count.
                if (d_req && !d_ready) begin
                    pipe_hold = 1'b1;
                end else begin
                    id_ex_bubble = 1'b1;
                    if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        state_d     = ST_HALT;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
            end
            ST_HALT: begin
                id_ex_bubble = 1'b1;
                halted       = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // A stall holds a branch until its operands are ready, and a flush
        // squashes the HLT on the wrong path, hence this ordering.
        if (run_rules) begin
            if (stall) begin
                id_ex_bubble = 1'b1;
                stall_hit    = 1'b1;
            end else if (flush_req) begin
                pc_write    = 1'b1;
                pc_sel      = 1'b1;
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
                flush_hit   = 1'b1;
            end else if (halt_in) begin
                state_d     = ST_DRAIN;
                drain_cnt_d = '0;
            end else if (!i_ready) begin
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
        end

        // While reset is held the front end is kept empty regardless of state.
        if (reset) begin
            pc_write     = 1'b0;
            pc_sel       = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pipe_hold    = 1'b0;
            halted       = 1'b0;
        end
    end

    // Event counters saturate at all-ones. The watchdog run length clears on
    // any cycle without an applied stall; the sticky flag sets on the stall
    // cycle that would push the run past STALL_LIMIT.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        consec_d    = '0;
        timeout_d   = timeout_q;

        if (stall_hit) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (consec_q == CONSEC_W'(STALL_LIMIT)) begin
                timeout_d = 1'b1;
                consec_d  = consec_q;
            end else begin
                consec_d = consec_q + 1'b1;
            end
        end

        if (flush_hit && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    assign stall_timeout = timeout_q;
    assign stall_count   = stall_cnt_q;
    assign flush_count   = flush_cnt_q;

endmodule
